// File: rtl/debounce_multi_if.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | debounce_multi_if                                                         |
// | Button conditioner bus: raw levels in, clean level and event pulses out.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface debounce_multi_if #(
    parameter int CHANNELS = 5
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_out;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] released;
    logic [CHANNELS-1:0] repeat_pulse;

    modport master (
        output btn_in,
        input  btn_out,
        input  pressed,
        input  released,
        input  repeat_pulse
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output pressed,
        output released,
        output repeat_pulse
    );
endinterface
`default_nettype wire

// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | debounce_multi                                                            |
// | Per-channel sync, debounce window, press/release pulses, auto-repeat.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module debounce_multi #(
    parameter int CHANNELS      = 5,
    parameter int STABLE_CYCLES = 5000000,
    parameter int CNT_WIDTH     = 23,
    parameter int RESET_LEVEL   = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_RATE   = 0,
    parameter int HOLD_WIDTH    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    localparam logic                 C_RST_LVL = (RESET_LEVEL != 0);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                 sync1_q;
        logic                 sync2_q;
        logic                 btn_q;
        logic                 btn_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 pressed_q;
        logic                 pressed_d;
        logic                 released_q;
        logic                 released_d;

        // Any cycle of agreement with the current level restarts the window.
        always_comb begin
            btn_d = btn_q;
            cnt_d = '0;
            if (sync2_q != btn_q) begin
                if (cnt_q == C_CNT_MAX) begin
                    btn_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            pressed_d  = btn_d & ~btn_q;
            released_d = ~btn_d & btn_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= C_RST_LVL;
                sync2_q    <= C_RST_LVL;
                btn_q      <= C_RST_LVL;
                cnt_q      <= '0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                sync1_q    <= bus.btn_in[i];
                sync2_q    <= sync1_q;
                btn_q      <= btn_d;
                cnt_q      <= cnt_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
            end
        end

        assign bus.btn_out[i]  = btn_q;
        assign bus.pressed[i]  = pressed_q;
        assign bus.released[i] = released_q;

        if (REPEAT_DELAY != 0) begin : g_rpt
            localparam logic [HOLD_WIDTH-1:0] C_DELAY_END = HOLD_WIDTH'(REPEAT_DELAY - 1);
            localparam logic [HOLD_WIDTH-1:0] C_RATE_END  = HOLD_WIDTH'(REPEAT_RATE - 1);

            rpt_state_e            state_q;
            rpt_state_e            state_d;
            logic [HOLD_WIDTH-1:0] hold_q;
            logic [HOLD_WIDTH-1:0] hold_d;
            logic                  rpt_q;
            logic                  rpt_d;

            // A release on the same edge as a due repeat suppresses the repeat.
            always_comb begin
                state_d = state_q;
                hold_d  = '0;
                rpt_d   = 1'b0;
                if (released_d) begin
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (pressed_d) begin
                                state_d = ST_WAIT;
                            end
                        end
                        ST_WAIT: begin
                            if (hold_q == C_DELAY_END) begin
                                rpt_d   = 1'b1;
                                state_d = ST_RPT;
                            end else begin
                                hold_d = hold_q + HOLD_WIDTH'(1);
                            end
                        end
                        ST_RPT: begin
                            if (hold_q == C_RATE_END) begin
                                rpt_d = 1'b1;
                            end else begin
                                hold_d = hold_q + HOLD_WIDTH'(1);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    hold_q  <= '0;
                    rpt_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    hold_q  <= hold_d;
                    rpt_q   <= rpt_d;
                end
            end

            assign bus.repeat_pulse[i] = rpt_q;
        end else begin : g_no_rpt
            assign bus.repeat_pulse[i] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel push-button conditioner for board switches and keys feeding the CPU's memory-mapped input port and the single-step/reset controls. Each channel synchronises a raw asynchronous input, debounces it with a programmable stability window, and emits a clean level plus one-cycle press and release pulses. An optional auto-repeat (typematic) mode pulses periodically while a key is held.

Parameters:
CHANNELS, 5, number of independent input channels
STABLE_CYCLES, 5000000, consecutive cycles the synchronised input must differ from btn_out before btn_out follows it; must be >= 2
CNT_WIDTH, 23, debounce counter width; must hold STABLE_CYCLES-1
RESET_LEVEL, 0, reset/initial value of the synchroniser flops and btn_out, all channels
REPEAT_DELAY, 0, cycles from a press until the first repeat pulse; 0 disables auto-repeat
REPEAT_RATE, 0, cycles between subsequent repeat pulses; ignored when REPEAT_DELAY=0; must be >= 1 otherwise
HOLD_WIDTH, 26, hold counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_in  input  CHANNELS  raw asynchronous button levels, bit i = channel i
btn_out  output  CHANNELS  debounced level
pressed  output  CHANNELS  one-cycle pulse on btn_out 0->1
released  output  CHANNELS  one-cycle pulse on btn_out 1->0
repeat_pulse  output  CHANNELS  one-cycle auto-repeat pulse while held

Behaviour:
- Reset (rst_n low, asynchronous): sync flops and btn_out = RESET_LEVEL; all counters 0; pressed, released, repeat_pulse = 0; repeat FSM = IDLE. Effective immediately, including mid-count or mid-repeat. No pulses generated by reset or reset release.
- Channels are fully independent; no shared state.
- Synchroniser: two flops per channel; s = second-stage output.
- Debounce counter, per channel, on each edge:
  - s == btn_out: cnt <= 0.
  - s != btn_out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s != btn_out and cnt == STABLE_CYCLES-1: btn_out <= s, cnt <= 0.
- A single cycle of agreement restarts the window; glitches shorter than STABLE_CYCLES never reach btn_out.
- Latency: btn_in held stable from edge e0 -> btn_out changes at edge e0+STABLE_CYCLES+1, i.e. the (STABLE_CYCLES+2)th sampling edge.
- pressed/released: registered; high for exactly the one cycle after the edge at which btn_out rises/falls. Never both high in the same cycle.
- Auto-repeat FSM (per channel, active only if REPEAT_DELAY != 0):
  - IDLE: hold <= 0. On btn_out 0->1 -> WAIT.
  - WAIT: hold <= hold+1. When hold == REPEAT_DELAY-1: repeat_pulse for one cycle, hold <= 0, -> RPT.
  - RPT: hold <= hold+1. When hold == REPEAT_RATE-1: repeat_pulse, hold <= 0.
  - Any state, btn_out 1->0: -> IDLE, hold <= 0, no repeat pulse that cycle (release wins over a coincident repeat).
- With press at edge R: repeat pulses follow edges R+REPEAT_DELAY, R+REPEAT_DELAY+REPEAT_RATE, and so on.
- With REPEAT_DELAY = 0: repeat_pulse is tied low and no hold counter is built.
- Counters never wrap: all compares are exact equality against bounds that the parameter constraints guarantee fit the counter width.

Test Plan:
- Reset values: CHANNELS=2, RESET_LEVEL=0, STABLE_CYCLES=4; assert rst_n=0 with btn_in=2'b11 -> btn_out=0, all pulses 0; release reset, hold btn_in -> btn_out[1:0]=2'b11 six edges after release, then pressed=2'b11 for exactly one cycle.
- Bounce rejection: STABLE_CYCLES=4; btn_in[0] toggles 1,0,1 every 2 cycles, then stays 1 -> btn_out[0] rises only 6 edges after the final 0->1; exactly one pressed pulse; no released pulse.
- Release path: from btn_out[0]=1, drop btn_in[0] to 0 -> released[0] is high for 1 cycle, 6 edges later; pressed stays 0.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_RATE=3; hold the channel for 20 cycles after the press edge R -> repeat_pulse after R+10, R+13, R+16, R+19; release -> no further pulses; FSM returns to IDLE.
- Channel independence and async reset mid-op: channel 1 in RPT while channel 0 is mid-count; pulse rst_n low between clock edges -> all outputs 0 before the next edge; afterwards both channels restart the full STABLE_CYCLES window.
- Repeat disabled: REPEAT_DELAY=0; hold the button 1000 cycles -> repeat_pulse never asserts.
